// File: rtl/mul_scheduler.sv
// mul_scheduler
//   Round-robin front end that shares one pipelined multiplier between N_REQ requesters.
//   Each cycle at most one requester is granted. Its operand pair is registered onto
//   mul_a/mul_b, and a {valid, id} tag follows the operation through the multiplier
//   latency. When the tag reaches the end of the pipe, the Y/Z results are registered
//   and returned to the requester that issued the operation.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         grant enable; low stops new grants
//   req_valid  per-requester operand valid
//   req_ready  one-hot combinational grant
//   req_a/b    packed operands, requester i at [i*W_IN +: W_IN]
//   mul_a/b    registered operands driven into the multiplier
//   mul_y/z    multiplier results, MUL_LAT cycles after mul_a/b
//   rsp_valid  one-hot single-cycle response strobe
//   rsp_id     binary index of the responding requester
//   rsp_y/z    registered results, held between responses
//   busy       state not idle, or operations still in flight

module mul_scheduler #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned W_IN    = 13,
   parameter int unsigned W_OUT   = 27,
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*W_IN-1:0]   req_a,
   input  logic [N_REQ*W_IN-1:0]   req_b,
   output logic [W_IN-1:0]         mul_a,
   output logic [W_IN-1:0]         mul_b,
   input  logic [W_OUT-1:0]        mul_y,
   input  logic [W_OUT-1:0]        mul_z,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [W_OUT-1:0]        rsp_y,
   output logic [W_OUT-1:0]        rsp_z,
   output logic                    busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                     state_q;
   logic [ID_W-1:0]            rr_q;
   logic [W_IN-1:0]            mul_a_q, mul_b_q;
   // Stage k holds the tag of the operation whose operands were on mul_a/b k cycles ago.
   logic [MUL_LAT:0]           tag_v_q;
   logic [MUL_LAT:0][ID_W-1:0] tag_id_q;
   logic [N_REQ-1:0]           rsp_valid_q;
   logic [ID_W-1:0]            rsp_id_q;
   logic [W_OUT-1:0]           rsp_y_q, rsp_z_q;

   logic                       any_valid;
   logic                       in_flight;
   logic                       grant_en;
   logic [N_REQ-1:0]           rot_valid;
   logic                       found;
   logic [ID_W-1:0]            off;
   logic [ID_W:0]              sel_sum;
   logic [ID_W-1:0]            grant_id;
   logic [N_REQ-1:0]           grant_oh;
   logic                       xfer;
   logic [ID_W-1:0]            rr_next;
   logic [W_IN-1:0]            a_sel, b_sel;

   assign any_valid = |req_valid;
   assign in_flight = |tag_v_q;
   assign grant_en  = en && (state_q != StDrain);

   // Rotate the valid vector so that bit 0 is the requester at the rr pointer. The lowest
   // set bit is then the offset of the winner from the pointer.
   always_comb begin
      rot_valid = N_REQ'({req_valid, req_valid} >> rr_q);
      found     = 1'b0;
      off       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            found = 1'b1;
            off   = ID_W'(k);
         end
      end
      sel_sum = {1'b0, rr_q} + {1'b0, off};
      if (sel_sum >= (ID_W+1)'(N_REQ)) begin
         sel_sum = sel_sum - (ID_W+1)'(N_REQ);
      end
      grant_id = sel_sum[ID_W-1:0];
      grant_oh = '0;
      if (grant_en && found) begin
         grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
      end
   end

   assign req_ready = grant_oh;
   assign xfer      = |(req_valid & grant_oh);
   assign rr_next   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign a_sel     = req_a[grant_id * W_IN +: W_IN];
   assign b_sel     = req_b[grant_id * W_IN +: W_IN];

   // Control FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (en && any_valid) state_q <= StRun;
            end
            StRun: begin
               if (!en) begin
                  state_q <= in_flight ? StDrain : StIdle;
               end else if (!any_valid && !in_flight) begin
                  state_q <= StIdle;
               end
            end
            StDrain: begin
               // Resuming work takes precedence over dropping back to idle.
               if (en && any_valid) begin
                  state_q <= StRun;
               end else if (!in_flight) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Issue, tag pipe and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q        <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         tag_v_q     <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         rsp_y_q     <= '0;
         rsp_z_q     <= '0;
      end else begin
         if (xfer) begin
            rr_q    <= rr_next;
            mul_a_q <= a_sel;
            mul_b_q <= b_sel;
         end
         tag_v_q  <= {tag_v_q[MUL_LAT-1:0], xfer};
         tag_id_q <= {tag_id_q[MUL_LAT-1:0], grant_id};
         // The last tag stage lines up with the cycle in which mul_y/z are valid.
         if (tag_v_q[MUL_LAT]) begin
            rsp_valid_q <= {{(N_REQ-1){1'b0}}, 1'b1} << tag_id_q[MUL_LAT];
            rsp_id_q    <= tag_id_q[MUL_LAT];
            rsp_y_q     <= mul_y;
            rsp_z_q     <= mul_z;
         end else begin
            rsp_valid_q <= '0;
         end
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_z     = rsp_z_q;
   assign busy      = (state_q != StIdle) || in_flight;

endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler
//   Bench for mul_scheduler with a behavioural multiplier (Y = A*B signed, Z = A+B
//   sign-extended, MUL_LAT cycles). A reference model predicts grants, busy and
//   responses every cycle, and tables plus hand-written sequences cover the corner cases.

module tb_mul_scheduler;

   localparam int unsigned N_REQ   = 4;
   localparam int unsigned W_IN    = 13;
   localparam int unsigned W_OUT   = 27;
   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  en = 1'b0;
   logic [N_REQ-1:0]      req_valid = '0;
   logic [N_REQ-1:0]      req_ready;
   logic [N_REQ*W_IN-1:0] req_a, req_b;
   logic [W_IN-1:0]       mul_a, mul_b;
   logic [W_OUT-1:0]      mul_y, mul_z;
   logic [N_REQ-1:0]      rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [W_OUT-1:0]      rsp_y, rsp_z;
   logic                  busy;

   logic [W_IN-1:0]       op_a [N_REQ];
   logic [W_IN-1:0]       op_b [N_REQ];

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;

   mul_scheduler #(
      .N_REQ(N_REQ), .W_IN(W_IN), .W_OUT(W_OUT), .MUL_LAT(MUL_LAT), .ID_W(ID_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .mul_z(mul_z),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_z(rsp_z),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_a[i*W_IN +: W_IN] = op_a[i];
         req_b[i*W_IN +: W_IN] = op_b[i];
      end
   end

   function automatic logic [W_OUT-1:0] f_y(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
      logic signed [W_OUT-1:0] sa, sbv;
      sa  = $signed({{(W_OUT-W_IN){a[W_IN-1]}}, a});
      sbv = $signed({{(W_OUT-W_IN){b[W_IN-1]}}, b});
      return sa * sbv;
   endfunction

   function automatic logic [W_OUT-1:0] f_z(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
      return {{(W_OUT-W_IN){a[W_IN-1]}}, a} + {{(W_OUT-W_IN){b[W_IN-1]}}, b};
   endfunction

   // Behavioural multiplier
   logic [W_OUT-1:0] y_pipe [MUL_LAT];
   logic [W_OUT-1:0] z_pipe [MUL_LAT];
   always @(posedge clk) begin
      y_pipe[0] <= f_y(mul_a, mul_b);
      z_pipe[0] <= f_z(mul_a, mul_b);
      for (int i = 1; i < MUL_LAT; i++) begin
         y_pipe[i] <= y_pipe[i-1];
         z_pipe[i] <= z_pipe[i-1];
      end
   end
   assign mul_y = y_pipe[MUL_LAT-1];
   assign mul_z = z_pipe[MUL_LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N_REQ-1:0] model_grant(input logic [N_REQ-1:0] v,
                                                    input int unsigned ptr);
      logic [N_REQ-1:0] r;
      r = '0;
      for (int k = 0; k < N_REQ; k++) begin
         automatic int unsigned idx = (ptr + k) % N_REQ;
         if (v[idx] && r == '0) r[idx] = 1'b1;
      end
      return r;
   endfunction

   // Scoreboard and reference model, evaluated mid-cycle
   typedef struct {
      int unsigned      cyc;
      int unsigned      id;
      logic [W_OUT-1:0] y;
      logic [W_OUT-1:0] z;
   } exp_t;
   typedef enum {MIdle, MRun, MDrain} mstate_e;

   exp_t             sb[$];
   exp_t             e_pop;
   exp_t             e_new;
   mstate_e          m_state = MIdle;
   int unsigned      m_ptr = 0;
   logic             m_pipe;
   logic [N_REQ-1:0] m_rdy;
   logic [N_REQ-1:0] m_oh;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_state = MIdle;
         m_ptr   = 0;
      end else begin
         while (sb.size() != 0 && sb[0].cyc < cyc) begin
            e_pop = sb.pop_front();
            check("rsp_missing", 64'(rsp_valid), 64'(1) << e_pop.id);
         end
         if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e_pop = sb.pop_front();
            m_oh = '0;
            m_oh[e_pop.id] = 1'b1;
            check("rsp_valid", rsp_valid, m_oh);
            check("rsp_id", rsp_id, e_pop.id);
            check("rsp_y", rsp_y, e_pop.y);
            check("rsp_z", rsp_z, e_pop.z);
         end else begin
            check("rsp_quiet", rsp_valid, '0);
         end
         m_pipe = (sb.size() != 0);
         m_rdy  = (en && m_state != MDrain) ? model_grant(req_valid, m_ptr) : '0;
         check("req_ready", req_ready, m_rdy);
         check("busy", busy, (m_state != MIdle) || m_pipe);
         for (int i = 0; i < N_REQ; i++) begin
            if (m_rdy[i]) begin
               e_new.cyc = cyc + MUL_LAT + 2;
               e_new.id  = i;
               e_new.y   = f_y(op_a[i], op_b[i]);
               e_new.z   = f_z(op_a[i], op_b[i]);
               sb.push_back(e_new);
               m_ptr = (i + 1) % N_REQ;
            end
         end
         case (m_state)
            MIdle:  if (en && |req_valid) m_state = MRun;
            MRun: begin
               if (!en) m_state = m_pipe ? MDrain : MIdle;
               else if (!(|req_valid) && !m_pipe) m_state = MIdle;
            end
            MDrain: begin
               if (en && |req_valid) m_state = MRun;
               else if (!m_pipe) m_state = MIdle;
            end
            default: m_state = MIdle;
         endcase
      end
   end

   typedef struct {
      logic             en;
      logic [N_REQ-1:0] valid;
      logic [N_REQ-1:0] rdy;
      logic             bsy;
   } vec_t;
   vec_t vt [19];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      repeat (n) tick();
   endtask

   task automatic run_rows(input int first, input int last);
      for (int r = first; r <= last; r++) begin
         en        = vt[r].en;
         req_valid = vt[r].valid;
         @(negedge clk);
         check($sformatf("tbl_ready[%0d]", r), req_ready, vt[r].rdy);
         check($sformatf("tbl_busy[%0d]", r), busy, vt[r].bsy);
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N_REQ-1:0] drain_rsp [7];
      logic             drain_bsy [7];

      // All four requesters from pointer 1, then the wrap case from pointer 2, then drain.
      for (int k = 0; k < 12; k++) begin
         vt[k].en    = 1'b1;
         vt[k].valid = 4'b1111;
         vt[k].rdy   = 4'b0001 << ((1 + k) % 4);
         vt[k].bsy   = (k != 0);
      end
      vt[12] = '{en: 1'b1, valid: 4'b0010, rdy: 4'b0010, bsy: 1'b0};
      vt[13] = '{en: 1'b1, valid: 4'b1001, rdy: 4'b1000, bsy: 1'b1};
      vt[14] = '{en: 1'b1, valid: 4'b1001, rdy: 4'b0001, bsy: 1'b1};
      vt[15] = '{en: 1'b1, valid: 4'b1001, rdy: 4'b1000, bsy: 1'b1};
      vt[16] = '{en: 1'b1, valid: 4'b0111, rdy: 4'b0001, bsy: 1'b0};
      vt[17] = '{en: 1'b1, valid: 4'b0111, rdy: 4'b0010, bsy: 1'b1};
      vt[18] = '{en: 1'b1, valid: 4'b0111, rdy: 4'b0100, bsy: 1'b1};
      drain_rsp = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
      drain_bsy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      op_a = '{13'h0123, 13'h1F00, 13'h0777, 13'h1555};
      op_b = '{13'h0011, 13'h0202, 13'h1FFE, 13'h0999};

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      check("rst_mul_a", mul_a, '0);
      check("rst_mul_b", mul_b, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_id", rsp_id, '0);
      check("rst_rsp_y", rsp_y, '0);
      check("rst_rsp_z", rsp_z, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", req_ready, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Single op from requester 0: grant in the idle cycle, response 6 cycles later
      op_a[0] = 13'h1FFF;
      op_b[0] = 13'h1FFF;
      en = 1'b1;
      req_valid = 4'b0001;
      @(negedge clk);
      check("t1_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("t1_mul_a", mul_a, 13'h1FFF);
      check("t1_mul_b", mul_b, 13'h1FFF);
      repeat (5) tick();
      @(negedge clk);
      check("t1_rsp_valid", rsp_valid, 4'b0001);
      check("t1_rsp_id", rsp_id, 2'd0);
      check("t1_rsp_y", rsp_y, 27'd1);
      check("t1_rsp_z", rsp_z, 27'h7FFFFFE);
      tick();
      @(negedge clk);
      check("t1_rsp_strobe", rsp_valid, 4'b0000);
      check("t1_rsp_y_hold", rsp_y, 27'd1);
      idle(4);

      op_a[0] = 13'h0123;
      op_b[0] = 13'h0011;
      run_rows(0, 11);
      idle(10);
      run_rows(12, 15);
      idle(10);

      // Three in flight, then en drops
      run_rows(16, 18);
      en = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check($sformatf("drain_ready[%0d]", k), req_ready, '0);
         check($sformatf("drain_rsp[%0d]", k), rsp_valid, drain_rsp[k]);
         check($sformatf("drain_busy[%0d]", k), busy, drain_bsy[k]);
         tick();
      end

      // Request held while disabled, granted the cycle en returns
      req_valid = 4'b0010;
      op_a[1] = 13'h0AAA;
      op_b[1] = 13'h0A8A;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("dis_ready[%0d]", k), req_ready, '0);
         tick();
      end
      en = 1'b1;
      @(negedge clk);
      check("en_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      repeat (5) tick();
      @(negedge clk);
      check("en_rsp_valid", rsp_valid, 4'b0010);
      check("en_rsp_id", rsp_id, 2'd1);
      check("en_rsp_y", rsp_y, 27'd7365540);
      check("en_rsp_z", rsp_z, 27'd5428);
      idle(8);

      // Reset with two ops in flight
      op_a[2] = 13'h0F0F;
      op_b[2] = 13'h0033;
      req_valid = 4'b1100;
      repeat (2) tick();
      req_valid = '0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_mul_a", mul_a, '0);
      check("arst_mul_b", mul_b, '0);
      check("arst_rsp_id", rsp_id, '0);
      check("arst_rsp_y", rsp_y, '0);
      check("arst_rsp_z", rsp_z, '0);
      check("arst_busy", busy, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("arst_no_rsp[%0d]", k), rsp_valid, '0);
         tick();
      end

      en = 1'b0;
      idle(3);
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
